icap_arbiter: RTL
=================

// Module: icap_arbiter
// PURPOSE
//  Shares the single ICAP write port between two bitstream sources (req0 = PCIe DMA FIFO, req1 = flash loader FIFO).
//  Grants one requester per whole bitstream, reads its 256-bit FIFO words and serializes each into 32-bit ICAP writes.
//  Drives ICAP CSIB/RDWRB (active-low) directly.
//  Sits between the per-source bitstream FIFOs and the ICAP primitive.
// PARAMETERS
//  DATA_SIZE  256  FIFO word width; must be a multiple of 32.
//  BIT_SWAP   1    1: reverse bit order within each byte of every ICAP word (Virtex ICAP ordering). 0: pass through.
// PORTS
//  clock        in   1          system clock
//  reset        in   1          synchronous, active-high
//  req0_empty   in   1          req0 FIFO empty
//  req0_rd_en   out  1          req0 FIFO read strobe, active-high; data valid the following cycle
//  req0_data    in   DATA_SIZE  req0 FIFO read data
//  req0_last    in   1          sideband bit read with req0_data; marks final word of bitstream
//  req1_*       --   --         identical set for requester 1
//  abort        in   1          1-cycle pulse: terminate the current bitstream
//  grant        out  2          one-hot owner; 2'b00 when free
//  icap_csib    out  1          ICAP chip select, active-low
//  icap_rdwrb   out  1          ICAP direction; held 0 (write)
//  icap_i       out  32         ICAP write data
//  busy         out  1          1 while grant != 0
// BEHAVIOUR
//  Reset values: grant=0, rd_en=0, icap_csib=1, icap_rdwrb=0, icap_i=0, busy=0, rr_ptr=0, state=IDLE.
//  WORDS = DATA_SIZE/32; beat counter is clog2(WORDS) bits wide and wraps at WORDS-1.
//  States:
//   IDLE: if either req_empty=0, grant the requester selected by rr_ptr on ties (rr_ptr=0 -> req0); -> READ.
//   READ: assert granted rd_en for exactly 1 cycle; -> CAPTURE.
//   CAPTURE: latch data and last into the shift register; beat=0; -> SHIFT.
//   SHIFT: csib=0; icap_i = word[beat*32 +: 32] (lowest slice first), bit-swapped if BIT_SWAP=1; beat++.
//    At beat==WORDS-1:
//     - last=1 -> RELEASE
//     - else if granted empty=0 -> READ
//     - else -> HOLD
//   HOLD: csib=1; grant is kept; -> READ when granted empty=0. The other requester is never serviced mid-bitstream.
//   RELEASE: csib=1; grant=0; rr_ptr = ~(index of released requester); -> IDLE.
//  Outputs are registered: csib/icap_i change 1 cycle after the state decision.
//  Outside SHIFT: csib=1 and icap_i holds its last value.
//  Throughput: WORDS ICAP writes per WORDS+2 cycles while the FIFO stays non-empty.
//  abort: from any state except IDLE -> RELEASE next cycle.
//   - csib deasserts on the following edge; the remaining beats of the current word are dropped.
//   - no further rd_en is issued.
//   - abort in IDLE is ignored.
//  An empty flag of the non-granted requester has no effect on the active transfer.
//  rd_en is never asserted when the granted empty=1; if empty=1 at the READ decision, the FSM goes to HOLD instead.
//  reset mid-transfer: the next cycle shows all reset values; the partially shifted word is discarded.
//  req_data and req_last are sampled only in CAPTURE.
// STRUCTURE
//  Package icap_pkg: state localparams (IDLE, READ, CAPTURE, SHIFT, HOLD, RELEASE, 3 bits), ICAP_W=32, and function bitswap8(32b).
//  Sub-module icap_word_serializer: load pulse, DATA_SIZE shift register, beat counter, BIT_SWAP.
//   Outputs icap_i and done_beat.
//  Arbitration and the FSM stay in icap_arbiter.
// TESTING
//  1. req0 supplies 2 words, the second with last=1, data 32'h00000001..32'h00000010 in order.
//     -> 16 writes with csib=0, in ascending order; grant returns to 00 afterwards.
//  2. Both FIFOs go non-empty on the same cycle after reset.
//     -> req0 is granted first. After its bitstream, req1 is granted. A third tie then goes to req0.
//  3. req0 empties after word 1 (last=0) and refills 5 cycles later.
//     -> HOLD with csib=1 for the gap; grant stays 01 while req1 is non-empty; the stream resumes with word 2.
//  4. BIT_SWAP=1, slice 32'h01020304. -> icap_i=32'h8040C020. With BIT_SWAP=0: icap_i=32'h01020304.
//  5. abort pulsed at beat 3 of a word. -> csib=1 within 2 cycles; grant=0; no rd_en; req1 is served next.
//  6. reset asserted during SHIFT. -> all reset values on the next cycle; a fresh transfer starts from beat 0.

Source files
------------

// File: rtl/icap_pkg.sv
// Shared types and helpers for the ICAP arbiter: FSM state encoding, ICAP word
// width and the per-byte bit reversal used for Virtex ICAP ordering.
package icap_pkg;

   localparam int unsigned ICAP_W = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      SHIFT   = 3'd3,
      HOLD    = 3'd4,
      RELEASE = 3'd5
   } state_t;

   function automatic logic [ICAP_W-1:0] bitswap8(input logic [ICAP_W-1:0] w);
      logic [ICAP_W-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < ICAP_W / 8; b++) begin
         for (int unsigned i = 0; i < 8; i++) begin
            r[b*8 + i] = w[b*8 + 7 - i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/icap_word_serializer.sv
// Holds one FIFO word and emits it as ICAP-width slices, lowest slice first,
// one slice per shift pulse. icap_o is registered; done_beat_o flags the final slice.
module icap_word_serializer
   import icap_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 256,
   parameter bit          BIT_SWAP  = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic [DATA_SIZE-1:0] data_i,
   input  logic                 last_i,
   input  logic                 shift_i,
   output logic [ICAP_W-1:0]    icap_o,
   output logic                 done_beat_o,
   output logic                 last_o
);

   localparam int unsigned WORDS  = DATA_SIZE / ICAP_W;
   localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   logic [DATA_SIZE-1:0] word_q;
   logic [BEAT_W-1:0]    beat_q;
   logic                 last_q;
   logic [ICAP_W-1:0]    icap_q;
   logic [ICAP_W-1:0]    slice;
   logic [ICAP_W-1:0]    slice_out;

   assign slice     = word_q[ICAP_W-1:0];
   assign slice_out = BIT_SWAP ? bitswap8(slice) : slice;

   // Shifting right by one slice keeps the next slice in the low bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         word_q <= '0;
         beat_q <= '0;
         last_q <= 1'b0;
         icap_q <= '0;
      end else if (load_i) begin
         word_q <= data_i;
         last_q <= last_i;
         beat_q <= '0;
      end else if (shift_i) begin
         icap_q <= slice_out;
         word_q <= word_q >> ICAP_W;
         beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
   end

   assign icap_o      = icap_q;
   assign done_beat_o = (beat_q == LAST_BEAT);
   assign last_o      = last_q;

endmodule

// File: rtl/icap_arbiter.sv
// Round-robin owner of the ICAP write port: grants one FIFO source per whole
// bitstream and feeds its words through the serializer as 32-bit ICAP writes.
module icap_arbiter
   import icap_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 256,
   parameter bit          BIT_SWAP  = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0_empty,
   output logic                 req0_rd_en,
   input  logic [DATA_SIZE-1:0] req0_data,
   input  logic                 req0_last,
   input  logic                 req1_empty,
   output logic                 req1_rd_en,
   input  logic [DATA_SIZE-1:0] req1_data,
   input  logic                 req1_last,
   input  logic                 abort,
   output logic [1:0]           grant,
   output logic                 icap_csib,
   output logic                 icap_rdwrb,
   output logic [31:0]          icap_i,
   output logic                 busy
);

   state_t               state_q;
   logic [1:0]           grant_q;
   logic                 rd0_q;
   logic                 rd1_q;
   logic                 csib_q;
   logic                 rr_ptr_q;

   logic                 gnt_empty;
   logic                 pick1;
   logic [DATA_SIZE-1:0] cap_data;
   logic                 cap_last;
   logic                 load;
   logic                 shift;
   logic                 done_beat;
   logic                 word_last;
   logic [ICAP_W-1:0]    ser_word;

   assign gnt_empty = grant_q[1] ? req1_empty : req0_empty;
   // req1 wins when req0 is idle, or on a tie when the pointer favours it.
   assign pick1     = req0_empty | (~req1_empty & rr_ptr_q);
   assign cap_data  = grant_q[1] ? req1_data : req0_data;
   assign cap_last  = grant_q[1] ? req1_last : req0_last;
   assign load      = (state_q == CAPTURE);
   assign shift     = (state_q == SHIFT) && !abort;

   icap_word_serializer #(
      .DATA_SIZE (DATA_SIZE),
      .BIT_SWAP  (BIT_SWAP)
   ) u_ser (
      .clock       (clock),
      .reset       (reset),
      .load_i      (load),
      .data_i      (cap_data),
      .last_i      (cap_last),
      .shift_i     (shift),
      .icap_o      (ser_word),
      .done_beat_o (done_beat),
      .last_o      (word_last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rd0_q    <= 1'b0;
         rd1_q    <= 1'b0;
         csib_q   <= 1'b1;
         rr_ptr_q <= 1'b0;
      end else begin
         rd0_q <= 1'b0;
         rd1_q <= 1'b0;
         if (abort && state_q != IDLE && state_q != RELEASE) begin
            state_q <= RELEASE;
            csib_q  <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  csib_q <= 1'b1;
                  if (!req0_empty || !req1_empty) begin
                     grant_q <= pick1 ? 2'b10 : 2'b01;
                     rd0_q   <= ~pick1;
                     rd1_q   <= pick1;
                     state_q <= READ;
                  end
               end
               READ: begin
                  csib_q  <= 1'b1;
                  state_q <= CAPTURE;
               end
               CAPTURE: begin
                  csib_q  <= 1'b1;
                  state_q <= SHIFT;
               end
               SHIFT: begin
                  csib_q <= 1'b0;
                  if (done_beat) begin
                     if (word_last) begin
                        state_q <= RELEASE;
                     end else if (!gnt_empty) begin
                        rd0_q   <= grant_q[0];
                        rd1_q   <= grant_q[1];
                        state_q <= READ;
                     end else begin
                        state_q <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  csib_q <= 1'b1;
                  if (!gnt_empty) begin
                     rd0_q   <= grant_q[0];
                     rd1_q   <= grant_q[1];
                     state_q <= READ;
                  end
               end
               RELEASE: begin
                  csib_q   <= 1'b1;
                  grant_q  <= '0;
                  rr_ptr_q <= grant_q[0];
                  state_q  <= IDLE;
               end
               default: begin
                  csib_q  <= 1'b1;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign req0_rd_en = rd0_q;
   assign req1_rd_en = rd1_q;
   assign grant      = grant_q;
   assign icap_csib  = csib_q;
   assign icap_rdwrb = 1'b0;
   assign icap_i     = ser_word;
   assign busy       = |grant_q;

endmodule
